// File: rtl/gb_alu_pkg.sv
// Shared constants, shift op encodings and payload types for the ALU shift stage.
package gb_alu_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned GB_SHAMT_W = 7;
    localparam int unsigned GB_SH_W    = 6;
    localparam int unsigned GB_OP_W    = 3;

    typedef enum logic [GB_OP_W-1:0] {
        GB_SH_SLL  = 3'd0,
        GB_SH_SRL  = 3'd1,
        GB_SH_SRA  = 3'd2,
        GB_SH_SLLW = 3'd3,
        GB_SH_SRLW = 3'd4,
        GB_SH_SRAW = 3'd5
    } gb_sh_op_e;

    // Decoded op as held in the first pipeline slot (shamt already masked).
    typedef struct packed {
        logic [GB_OP_W-1:0] op;
        logic [XLEN-1:0]    rs1;
        logic [GB_SH_W-1:0] sh;
    } gb_sh_req_t;

    // True for the 32-bit word variants.
    function automatic logic is_word_op(logic [GB_OP_W-1:0] op);
        return (op == GB_SH_SLLW) || (op == GB_SH_SRLW) || (op == GB_SH_SRAW);
    endfunction

endpackage

// File: rtl/gb_alu_shift_stage_if.sv
// Issue-side and writeback-side handshake bundle of the shift stage.
interface gb_alu_shift_stage_if
    import gb_alu_pkg::*;
#(
    parameter int unsigned TAG_W = 5
);
    logic                  i_flush;
    logic                  i_valid;
    logic                  o_ready;
    logic [GB_OP_W-1:0]    i_op;
    logic [XLEN-1:0]       i_rs1;
    logic [GB_SHAMT_W-1:0] i_shamt;
    logic [TAG_W-1:0]      i_rd;
    logic                  o_valid;
    logic                  i_ready;
    logic [XLEN-1:0]       o_result;
    logic [TAG_W-1:0]      o_rd;
    logic                  o_illegal;

    // Stage side.
    modport slave (
        input  i_flush, i_valid, i_op, i_rs1, i_shamt, i_rd, i_ready,
        output o_ready, o_valid, o_result, o_rd, o_illegal
    );

    // Issue/writeback side.
    modport master (
        output i_flush, i_valid, i_op, i_rs1, i_shamt, i_rd, i_ready,
        input  o_ready, o_valid, o_result, o_rd, o_illegal
    );
endinterface

// File: rtl/gb_alu_shifter.sv
// Combinational log-stage barrel shifter; left shifts reuse the right-shift
// network by bit-reversing the data on the way in and out.
module gb_alu_shifter
    import gb_alu_pkg::*;
(
    input  logic [XLEN-1:0]    i_data,
    input  logic [GB_SH_W-1:0] i_sh,
    input  logic               i_left,
    input  logic               i_fill,
    output logic [XLEN-1:0]    o_data_c
);

    function automatic logic [XLEN-1:0] bit_rev(logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        for (int i = 0; i < int'(XLEN); i++) begin
            r[i] = d[XLEN-1-i];
        end
        return r;
    endfunction

    logic            fill;
    logic [XLEN-1:0] pre;
    logic [XLEN-1:0] s0, s1, s2, s3, s4, s5;

    // Six right-shift stages of 1/2/4/8/16/32 bits.
    always_comb begin
        fill     = i_fill & ~i_left;
        pre      = i_left ? bit_rev(i_data) : i_data;
        s0       = i_sh[0] ? {{1{fill}},  pre[XLEN-1:1]}  : pre;
        s1       = i_sh[1] ? {{2{fill}},  s0[XLEN-1:2]}   : s0;
        s2       = i_sh[2] ? {{4{fill}},  s1[XLEN-1:4]}   : s1;
        s3       = i_sh[3] ? {{8{fill}},  s2[XLEN-1:8]}   : s2;
        s4       = i_sh[4] ? {{16{fill}}, s3[XLEN-1:16]}  : s3;
        s5       = i_sh[5] ? {{32{fill}}, s4[XLEN-1:32]}  : s4;
        o_data_c = i_left ? bit_rev(s5) : s5;
    end

endmodule

// File: rtl/gb_alu_shift_stage.sv
// Two-slot registered RV64 shift execute stage with valid/ready on both sides.
module gb_alu_shift_stage
    import gb_alu_pkg::*;
#(
    parameter int unsigned TAG_W = 5
)(
    input  logic                 i_clk,
    input  logic                 i_rst,
    gb_alu_shift_stage_if.slave  bus
);

    logic             s1_valid_q, s1_valid_d;
    gb_sh_req_t       s1_req_q,   s1_req_d;
    logic [TAG_W-1:0] s1_rd_q,    s1_rd_d;
    logic             s2_valid_q, s2_valid_d;
    logic [XLEN-1:0]  s2_result_q, s2_result_d;
    logic [TAG_W-1:0] s2_rd_q,    s2_rd_d;
    logic             s2_illegal_q, s2_illegal_d;

    logic            s2_adv_c, s1_adv_c, ready_c, in_xfer_c;
    logic            word_c, left_c, arith_c, illegal_c;
    logic            fill_c;
    logic [XLEN-1:0] sh_in_c, sh_out_c, result_c;

    // Bit 6 of the raw shift amount never affects the result.
    logic unused_shamt_msb;
    assign unused_shamt_msb = bus.i_shamt[6];

    // Word pre-masking, fill selection and sign extension around the shifter.
    always_comb begin
        word_c    = is_word_op(s1_req_q.op);
        left_c    = (s1_req_q.op == GB_SH_SLL) || (s1_req_q.op == GB_SH_SLLW);
        arith_c   = (s1_req_q.op == GB_SH_SRA) || (s1_req_q.op == GB_SH_SRAW);
        illegal_c = s1_req_q.op > GB_OP_W'(GB_SH_SRAW);
        fill_c    = arith_c & (word_c ? s1_req_q.rs1[WORD_W-1] : s1_req_q.rs1[XLEN-1]);
        sh_in_c   = word_c ? {{WORD_W{fill_c}}, s1_req_q.rs1[WORD_W-1:0]} : s1_req_q.rs1;
        result_c  = sh_out_c;
        if (word_c) begin
            result_c = {{WORD_W{sh_out_c[WORD_W-1]}}, sh_out_c[WORD_W-1:0]};
        end
        if (illegal_c) begin
            result_c = '0;
        end
    end

    gb_alu_shifter u_shifter (
        .i_data   (sh_in_c),
        .i_sh     (s1_req_q.sh),
        .i_left   (left_c),
        .i_fill   (fill_c),
        .o_data_c (sh_out_c)
    );

    // Handshake and slot next-state; flush wins over every transfer.
    always_comb begin
        s2_adv_c  = !s2_valid_q || bus.i_ready;
        s1_adv_c  = !s1_valid_q || s2_adv_c;
        ready_c   = s1_adv_c && !bus.i_flush;
        in_xfer_c = bus.i_valid && ready_c;

        s1_valid_d   = s1_valid_q;
        s1_req_d     = s1_req_q;
        s1_rd_d      = s1_rd_q;
        s2_valid_d   = s2_valid_q;
        s2_result_d  = s2_result_q;
        s2_rd_d      = s2_rd_q;
        s2_illegal_d = s2_illegal_q;

        if (in_xfer_c) begin
            s1_req_d.op  = bus.i_op;
            s1_req_d.rs1 = bus.i_rs1;
            s1_req_d.sh  = is_word_op(bus.i_op) ? {1'b0, bus.i_shamt[4:0]} : bus.i_shamt[5:0];
            s1_rd_d      = bus.i_rd;
        end
        if (s1_adv_c) begin
            s1_valid_d = in_xfer_c;
        end
        if (s2_adv_c) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_result_d  = result_c;
                s2_rd_d      = s1_rd_q;
                s2_illegal_d = illegal_c;
            end
        end
        if (bus.i_flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    // Slot registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q   <= 1'b0;
            s1_req_q     <= '0;
            s1_rd_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_result_q  <= '0;
            s2_rd_q      <= '0;
            s2_illegal_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_req_q     <= s1_req_d;
            s1_rd_q      <= s1_rd_d;
            s2_valid_q   <= s2_valid_d;
            s2_result_q  <= s2_result_d;
            s2_rd_q      <= s2_rd_d;
            s2_illegal_q <= s2_illegal_d;
        end
    end

    assign bus.o_ready   = ready_c;
    assign bus.o_valid   = s2_valid_q;
    assign bus.o_result  = s2_result_q;
    assign bus.o_rd      = s2_rd_q;
    assign bus.o_illegal = s2_illegal_q;

endmodule

// File: tb/tb_gb_alu_shift_stage.sv
// Self-checking bench for gb_alu_shift_stage: directed corner values plus
// randomized streams checked against a queue-based reference model.
module tb_gb_alu_shift_stage;
    import gb_alu_pkg::*;

    localparam int unsigned TAG_W = 5;

    typedef struct {
        logic [63:0]      res;
        logic [TAG_W-1:0] rd;
        logic             ill;
        int               vis;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gb_alu_shift_stage_if #(.TAG_W(TAG_W)) bus ();
    gb_alu_shift_stage #(.TAG_W(TAG_W)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t mq[$];

    // Architectural shift result straight from the ISA definition.
    function automatic logic [63:0] ref_result(logic [2:0] op, logic [63:0] a, logic [6:0] shamt);
        int          s6;
        int          s5;
        logic [31:0] w;
        s6 = int'(shamt[5:0]);
        s5 = int'(shamt[4:0]);
        w  = '0;
        case (op)
            3'd0: return a << s6;
            3'd1: return a >> s6;
            3'd2: return $signed(a) >>> s6;
            3'd3: w = a[31:0] << s5;
            3'd4: w = a[31:0] >> s5;
            3'd5: w = $signed(a[31:0]) >>> s5;
            default: return 64'd0;
        endcase
        return {{32{w[31]}}, w};
    endfunction

    // Model: at most two ops in flight, each visible from cycle 'vis' onward.
    function automatic bit m_valid();
        return (mq.size() > 0) && (mq[0].vis <= cyc);
    endfunction

    function automatic bit m_ready();
        return !bus.i_flush && !((mq.size() == 2) && m_valid() && !bus.i_ready);
    endfunction

    task automatic drive(bit v, logic [2:0] op, logic [63:0] rs1, logic [6:0] sh,
                         logic [TAG_W-1:0] rd, bit rdy, bit fl);
        bus.i_valid = v;
        bus.i_op    = op;
        bus.i_rs1   = rs1;
        bus.i_shamt = sh;
        bus.i_rd    = rd;
        bus.i_ready = rdy;
        bus.i_flush = fl;
        #1;
    endtask

    // Advance model by the transfers implied by current inputs, then one clock.
    task automatic tick();
        bit   pop;
        bit   push;
        exp_t e;
        pop  = m_valid() && bus.i_ready && !bus.i_flush;
        push = bus.i_valid && m_ready();
        if (rst || bus.i_flush) begin
            mq.delete();
        end else begin
            if (pop) begin
                void'(mq.pop_front());
                if (mq.size() > 0) begin
                    e = mq.pop_front();
                    if (e.vis < cyc + 1) e.vis = cyc + 1;
                    mq.push_front(e);
                end
            end
            if (push) begin
                e.res = ref_result(bus.i_op, bus.i_rs1, bus.i_shamt);
                e.rd  = bus.i_rd;
                e.ill = bus.i_op > 3'd5;
                e.vis = cyc + 2;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 3'd0, 64'd0, 7'd0, '0, 1, 0);
        tick();
        drive(0, 3'd0, 64'd0, 7'd0, '0, 1, 0);
        n_cmp++;
        if ({bus.o_valid, bus.o_result, bus.o_rd, bus.o_illegal} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got v=%b res=%h rd=%0d ill=%b want all zero",
                     bus.o_valid, bus.o_result, bus.o_rd, bus.o_illegal);
        end
        tick();
        rst = 1'b0;
        drive(0, 3'd0, 64'd0, 7'd0, '0, 1, 0);
        n_cmp++;
        if (bus.o_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready got %b want 1", bus.o_ready);
        end
    endtask

    task automatic test_directed();
        logic [2:0]       t_op [10] = '{3'd0, 3'd5, 3'd4, 3'd2, 3'd0, 3'd4, 3'd3, 3'd1, 3'd7, 3'd6};
        logic [63:0]      t_a  [10] = '{64'h1, 64'h8000_0000, 64'h8000_0000, 64'h8000_0000_0000_0000,
                                        64'h1, 64'hFFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000,
                                        64'hDEAD_BEEF, 64'h1234};
        logic [6:0]       t_sh [10] = '{7'h43, 7'd4, 7'd0, 7'd63, 7'd63, 7'd31, 7'd31, 7'h7F, 7'd3, 7'd1};
        logic [63:0]      t_x  [10] = '{64'h8, 64'hFFFF_FFFF_F800_0000, 64'hFFFF_FFFF_8000_0000,
                                        64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h1,
                                        64'hFFFF_FFFF_8000_0000, 64'h1, 64'h0, 64'h0};
        logic             t_il [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        logic [TAG_W-1:0] rd;
        for (int i = 0; i < 10; i++) begin
            rd = (i == 8) ? TAG_W'(9) : TAG_W'(i + 3);
            drive(1, t_op[i], t_a[i], t_sh[i], rd, 1, 0);
            tick();
            drive(0, 3'd0, 64'd0, 7'd0, '0, 1, 0);
            n_cmp++;
            if (bus.o_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL directed_early[%0d] o_valid got %b want 0", i, bus.o_valid);
            end
            tick();
            drive(0, 3'd0, 64'd0, 7'd0, '0, 1, 0);
            n_cmp++;
            if (bus.o_valid !== 1'b1 || bus.o_result !== t_x[i] || bus.o_illegal !== t_il[i] || bus.o_rd !== rd) begin
                n_bad++;
                $display("FAIL directed[%0d] got v=%b res=%h ill=%b rd=%0d want v=1 res=%h ill=%b rd=%0d",
                         i, bus.o_valid, bus.o_result, bus.o_illegal, bus.o_rd, t_x[i], t_il[i], rd);
            end
            tick();
        end
    endtask

    task automatic test_stream();
        int first_acc = -1;
        int first_val = -1;
        int last_val  = -1;
        int n_val     = 0;
        for (int i = 0; i < 12; i++) begin
            drive(i < 8, 3'($urandom_range(0, 5)), {$urandom, $urandom}, 7'($urandom),
                  TAG_W'(i), 1, 0);
            n_cmp++;
            if (bus.o_valid !== m_valid() || bus.o_ready !== m_ready()) begin
                n_bad++;
                $display("FAIL stream_hs cyc=%0d got v=%b r=%b want v=%b r=%b",
                         cyc, bus.o_valid, bus.o_ready, m_valid(), m_ready());
            end
            if (m_valid()) begin
                n_cmp++;
                if (bus.o_result !== mq[0].res || bus.o_rd !== mq[0].rd || bus.o_illegal !== mq[0].ill) begin
                    n_bad++;
                    $display("FAIL stream_data cyc=%0d got %h/%0d/%b want %h/%0d/%b", cyc,
                             bus.o_result, bus.o_rd, bus.o_illegal, mq[0].res, mq[0].rd, mq[0].ill);
                end
            end
            if (bus.o_valid === 1'b1) begin
                n_val++;
                if (first_val < 0) first_val = cyc;
                last_val = cyc;
            end
            if (i == 0) first_acc = cyc;
            tick();
        end
        n_cmp++;
        if (n_val != 8 || first_val != first_acc + 2 || last_val != first_val + 7) begin
            n_bad++;
            $display("FAIL stream_timing got n=%0d first=%0d last=%0d want n=8 first=%0d last=%0d",
                     n_val, first_val, last_val, first_acc + 2, first_acc + 9);
        end
    endtask

    task automatic test_backpressure();
        logic [2:0]  ops [12];
        logic [63:0] a   [12];
        logic [6:0]  sh  [12];
        int n_in  = 0;
        int n_out = 0;
        bit rdy;
        for (int i = 0; i < 12; i++) begin
            ops[i] = 3'($urandom_range(0, 7));
            a[i]   = {$urandom, $urandom};
            sh[i]  = 7'($urandom);
        end
        for (int c = 0; c < 40; c++) begin
            rdy = !(c >= 2 && c <= 6);
            if (n_in < 12) drive(1, ops[n_in], a[n_in], sh[n_in], TAG_W'(n_in + 16), rdy, 0);
            else           drive(0, 3'd0, 64'd0, 7'd0, '0, rdy, 0);
            n_cmp++;
            if (bus.o_valid !== m_valid() || bus.o_ready !== m_ready()) begin
                n_bad++;
                $display("FAIL bp_hs cyc=%0d got v=%b r=%b want v=%b r=%b",
                         cyc, bus.o_valid, bus.o_ready, m_valid(), m_ready());
            end
            if (m_valid()) begin
                n_cmp++;
                if (bus.o_result !== mq[0].res || bus.o_rd !== mq[0].rd || bus.o_illegal !== mq[0].ill) begin
                    n_bad++;
                    $display("FAIL bp_data cyc=%0d got %h/%0d/%b want %h/%0d/%b", cyc,
                             bus.o_result, bus.o_rd, bus.o_illegal, mq[0].res, mq[0].rd, mq[0].ill);
                end
            end
            if (bus.i_valid && m_ready()) n_in++;
            if (m_valid() && rdy) n_out++;
            tick();
        end
        n_cmp++;
        if (n_in != 12 || n_out != 12 || mq.size() != 0) begin
            n_bad++;
            $display("FAIL bp_drain got in=%0d out=%0d left=%0d want 12/12/0", n_in, n_out, mq.size());
        end
    endtask

    task automatic test_flush();
        bit               t_v  [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
        bit               t_fl [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
        bit               t_rd [8] = '{1, 1, 0, 1, 1, 1, 1, 1};
        logic [63:0]      d_a;
        d_a = 64'h0000_0000_F000_000F;
        for (int c = 0; c < 8; c++) begin
            drive(t_v[c], 3'd1, d_a + 64'(c), 7'(c + 1), TAG_W'(c + 20), t_rd[c], t_fl[c]);
            n_cmp++;
            if (bus.o_valid !== m_valid() || bus.o_ready !== m_ready()) begin
                n_bad++;
                $display("FAIL flush_hs c=%0d got v=%b r=%b want v=%b r=%b",
                         c, bus.o_valid, bus.o_ready, m_valid(), m_ready());
            end
            if (c == 3) begin
                n_cmp++;
                if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL flush_clear got v=%b r=%b want v=0 r=1", bus.o_valid, bus.o_ready);
                end
            end
            if (c == 5) begin
                n_cmp++;
                if (bus.o_valid !== 1'b1 || bus.o_rd !== TAG_W'(23) || bus.o_result !== ((d_a + 64'd3) >> 4)) begin
                    n_bad++;
                    $display("FAIL flush_after got v=%b rd=%0d res=%h want v=1 rd=23 res=%h",
                             bus.o_valid, bus.o_rd, bus.o_result, (d_a + 64'd3) >> 4);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        for (int c = 0; c < 3; c++) begin
            drive(1, 3'd5, {$urandom, $urandom}, 7'($urandom), TAG_W'(c + 1), 0, 0);
            tick();
        end
        rst = 1'b1;
        drive(0, 3'd0, 64'd0, 7'd0, '0, 0, 0);
        tick();
        n_cmp++;
        if ({bus.o_valid, bus.o_result, bus.o_rd, bus.o_illegal} !== '0) begin
            n_bad++;
            $display("FAIL midreset got v=%b res=%h rd=%0d ill=%b want all zero",
                     bus.o_valid, bus.o_result, bus.o_rd, bus.o_illegal);
        end
        rst = 1'b0;
        drive(0, 3'd0, 64'd0, 7'd0, '0, 1, 0);
        tick();
        drive(0, 3'd0, 64'd0, 7'd0, '0, 1, 0);
        n_cmp++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_after got v=%b r=%b want v=0 r=1", bus.o_valid, bus.o_ready);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), {$urandom, $urandom},
                  7'($urandom), TAG_W'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3);
            n_cmp++;
            if (bus.o_valid !== m_valid() || bus.o_ready !== m_ready()) begin
                n_bad++;
                $display("FAIL rand_hs cyc=%0d got v=%b r=%b want v=%b r=%b",
                         cyc, bus.o_valid, bus.o_ready, m_valid(), m_ready());
            end
            if (m_valid()) begin
                n_cmp++;
                if (bus.o_result !== mq[0].res || bus.o_rd !== mq[0].rd || bus.o_illegal !== mq[0].ill) begin
                    n_bad++;
                    $display("FAIL rand_data cyc=%0d got %h/%0d/%b want %h/%0d/%b", cyc,
                             bus.o_result, bus.o_rd, bus.o_illegal, mq[0].res, mq[0].rd, mq[0].ill);
                end
            end
            tick();
        end
        drive(0, 3'd0, 64'd0, 7'd0, '0, 1, 0);
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gb_alu_shift_stage.md
Name: gb_alu_shift_stage

Overview:
- Registered execute-stage shift unit for the 64-bit integer pipeline.
- Accepts decoded shift micro-ops from issue over a valid/ready handshake and performs RV64 SLL/SRL/SRA and the word variants SLLW/SRLW/SRAW.
- Delivers results to writeback over a second valid/ready handshake.
- Fixed 2-cycle pipeline with full backpressure and flush.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- TAG_W, 5, destination register tag width.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_flush  in  1  kill all in-flight ops this cycle.
- i_valid  in  1  issue presents an op.
- o_ready  out  1  stage can accept an op this cycle.
- i_op  in  3  0=SLL 1=SRL 2=SRA 3=SLLW 4=SRLW 5=SRAW; 6 and 7 are illegal.
- i_rs1  in  64  operand to shift.
- i_shamt  in  7  raw shift amount, taken from the rs2/imm low bits.
- i_rd  in  TAG_W  destination tag, passed through unchanged.
- o_valid  out  1  result available.
- i_ready  in  1  writeback accepts the result.
- o_result  out  64  shifted result.
- o_rd  out  TAG_W  tag of the result.
- o_illegal  out  1  result came from an illegal op code.

Behaviour:
- Two register slots:
  - S1 holds op, rs1, masked shamt and rd.
  - S2 holds result, rd and illegal flag. S2 drives o_result, o_rd and o_illegal directly (registered outputs).
- Handshake:
  - s2_adv = !s2_valid | i_ready
  - s1_adv = !s1_valid | s2_adv
  - o_ready = s1_adv & !i_flush
  - Input transfer on i_valid & o_ready. Output transfer on o_valid & i_ready.
  - o_ready may depend combinationally on i_ready.
- Latency: an op accepted in cycle N shows o_valid=1 in cycle N+2 with no backpressure. Throughput is 1 op per cycle.
- Backpressure:
  - While o_valid=1 and i_ready=0, S2 and its outputs hold stable.
  - S1 fills once. After that, o_ready=0.
  - No op is lost or duplicated.
- Shamt masking, done at S1 capture:
  - 64-bit ops use i_shamt[5:0].
  - W ops use i_shamt[4:0].
  - i_shamt[6] is always ignored.
- Arithmetic, computed combinationally between S1 and S2:
  - SLL: rs1 << sh.
  - SRL: logical right shift, zero fill.
  - SRA: arithmetic right shift, fill with rs1[63].
  - SLLW / SRLW / SRAW: operate on rs1[31:0]. Fill for SRAW is rs1[31]; for SRLW it is zero. The 32-bit result is sign-extended from its bit 31 to 64 bits, for all three W ops including SRLW.
  - Illegal op: result = 0, o_illegal = 1, rd is passed through.
- Boundaries:
  - sh=0: result equals the input, with W ops still sign-extended.
  - sh=63 (64-bit) or sh=31 (W): full-width shifts are handled correctly.
- Flush:
  - S1 and S2 valid clear at the next edge.
  - Any input presented in the flush cycle is not accepted.
  - Data registers may keep stale values.
- Simultaneous events:
  - S2 consumes while S1 advances and a new op enters: all three happen in the same cycle.
  - Flush overrides every other transfer.
- Reset:
  - At the next edge after i_rst=1: s1_valid=0, s2_valid=0, o_valid=0, o_result=0, o_rd=0, o_illegal=0. S1 data regs are cleared to 0.
  - o_ready=1 in the first cycle after reset deasserts.
  - A reset asserted mid-operation discards all in-flight ops.

Decomposition:
- Package gb_alu_pkg holds:
  - XLEN.
  - Shift op encodings (GB_SH_SLL … GB_SH_SRAW).
  - The shamt width constant (7).
- Sub-module gb_alu_shifter:
  - Combinational 64-bit log-stage barrel shifter.
  - Inputs: data, sh[5:0], dir (left/right), fill bit.
  - The stage handles W pre-masking/fill selection and sign extension around it.
  - The stage owns only the registers and the handshake.

Test Plan:
- Reset then single SLL, rs1=0x1, shamt=0x43, i_ready=1 → 2 cycles later o_result=0x8 (bit 6 of the 7-bit shamt ignored, sh=3), o_illegal=0.
- SRAW rs1=0x00000000_80000000, shamt=4 → 0xFFFFFFFF_F8000000. SRLW same input, shamt=0 → 0xFFFFFFFF_80000000. SRA rs1=0x8000000000000000, shamt=63 → 0xFFFFFFFFFFFFFFFF.
- Back-to-back stream of 8 ops with i_ready=1 → o_valid for 8 consecutive cycles starting 2 cycles after first accept. Results and rd tags are in order.
- Backpressure: i_ready=0 for 5 cycles while streaming → o_ready drops after S1 fills. o_result/o_rd stay stable. On release, all ops drain in order with no loss.
- i_op=7, rd=9 → o_result=0, o_illegal=1, o_rd=9.
- Two ops in flight, assert i_flush with i_valid=1 → next cycle o_valid=0. The flushed input is not accepted. A subsequent op completes normally with 2-cycle latency.
